// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory access stage: byte-wide bus sequencer with stall and registered writeback outputs
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] pc_in,
    input  logic [32:0] control_signals_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic [32:0] control_signals_out,
    output logic [15:0] pc_out,
    output logic [15:0] rdata_out,
    output logic        valid_out
);

    // Memory-op flags occupy the low nibble of the control word.
    localparam int MEM_READ_B_BIT  = 0;
    localparam int MEM_READ_W_BIT  = 1;
    localparam int MEM_WRITE_B_BIT = 2;
    localparam int MEM_WRITE_W_BIT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic is_mem;
        logic is_write;
        logic is_word;
    } op_t;

    // Write beats read; word beats byte within the chosen direction.
    function automatic op_t ctrl_decode(input logic [3:0] mem_bits);
        op_t op;
        logic rb, rw, wb, ww;
        rb = mem_bits[MEM_READ_B_BIT];
        rw = mem_bits[MEM_READ_W_BIT];
        wb = mem_bits[MEM_WRITE_B_BIT];
        ww = mem_bits[MEM_WRITE_W_BIT];
        op.is_write = wb | ww;
        op.is_mem   = wb | ww | rb | rw;
        op.is_word  = op.is_write ? ww : rw;
        return op;
    endfunction

    state_t      state;
    op_t         in_op;
    logic [15:0] cap_pc;
    logic [32:0] cap_ctrl;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata_hi;
    logic        cap_write;
    logic        cap_word;
    logic [15:0] data;

    assign in_op = ctrl_decode(control_signals_in[3:0]);

    // Stall is combinational so upstream freezes in the very cycle a memory op shows up.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = (state == BYTE0) || (state == BYTE1) ||
                    ((state == IDLE) && en && in_op.is_mem);
        end
    end

    // Main sequencer: captures the op, walks the bus bytes, retires to writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            cap_pc              <= '0;
            cap_ctrl            <= '0;
            cap_addr            <= '0;
            cap_wdata_hi        <= '0;
            cap_write           <= 1'b0;
            cap_word            <= 1'b0;
            data                <= '0;
            bus_req             <= 1'b0;
            bus_we              <= 1'b0;
            bus_addr            <= '0;
            bus_wdata           <= '0;
            control_signals_out <= '0;
            pc_out              <= '0;
            rdata_out           <= '0;
            valid_out           <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (!in_op.is_mem) begin
                            control_signals_out <= control_signals_in;
                            pc_out              <= pc_in;
                            rdata_out           <= addr_in;
                            valid_out           <= 1'b1;
                        end else begin
                            cap_pc       <= pc_in;
                            cap_ctrl     <= control_signals_in;
                            cap_addr     <= addr_in;
                            cap_wdata_hi <= wdata_in[15:8];
                            cap_write    <= in_op.is_write;
                            cap_word     <= in_op.is_word;
                            data         <= '0;
                            bus_req      <= 1'b1;
                            bus_we       <= in_op.is_write;
                            bus_addr     <= addr_in;
                            bus_wdata    <= wdata_in[7:0];
                            state        <= BYTE0;
                        end
                    end
                end
                BYTE0: begin
                    if (bus_ack) begin
                        if (!cap_write) begin
                            data[7:0] <= bus_rdata;
                        end
                        if (cap_word) begin
                            bus_addr  <= cap_addr + 16'd1;
                            bus_wdata <= cap_wdata_hi;
                            state     <= BYTE1;
                        end else begin
                            bus_req   <= 1'b0;
                            bus_we    <= 1'b0;
                            bus_addr  <= '0;
                            bus_wdata <= '0;
                            state     <= DONE;
                        end
                    end
                end
                BYTE1: begin
                    if (bus_ack) begin
                        if (!cap_write) begin
                            data[15:8] <= bus_rdata;
                        end
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    control_signals_out <= cap_ctrl;
                    pc_out              <= cap_pc;
                    valid_out           <= 1'b1;
                    if (cap_write) begin
                        rdata_out <= 16'h0000;
                    end else if (cap_word) begin
                        rdata_out <= data;
                    end else begin
                        rdata_out <= {8'h00, data[7:0]};
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] pc_in;
    logic [32:0] control_signals_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic [32:0] control_signals_out;
    logic [15:0] pc_out;
    logic [15:0] rdata_out;
    logic        valid_out;

    mem_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .pc_in               (pc_in),
        .control_signals_in  (control_signals_in),
        .addr_in             (addr_in),
        .wdata_in            (wdata_in),
        .stall               (stall),
        .bus_req             (bus_req),
        .bus_we              (bus_we),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_rdata           (bus_rdata),
        .bus_ack             (bus_ack),
        .control_signals_out (control_signals_out),
        .pc_out              (pc_out),
        .rdata_out           (rdata_out),
        .valid_out           (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus responder: acks after ack_delay wait cycles, read data = addr[7:0] ^ 0xA5.
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          stab_err  = 0;
    logic [15:0] h_addr;
    logic [7:0]  h_wdata;
    logic        h_we;
    logic [15:0] tr_addr[$];
    logic [7:0]  tr_wdata[$];
    logic        tr_we[$];

    always @(negedge clk) begin
        if (rst || !bus_req) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (wait_cnt > 0 && (bus_addr !== h_addr || bus_wdata !== h_wdata || bus_we !== h_we))
                stab_err++;
            h_addr  = bus_addr;
            h_wdata = bus_wdata;
            h_we    = bus_we;
            if (wait_cnt >= ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = bus_addr[7:0] ^ 8'hA5;
                tr_addr.push_back(bus_addr);
                tr_wdata.push_back(bus_wdata);
                tr_we.push_back(bus_we);
                wait_cnt  = 0;
            end else begin
                bus_ack  = 1'b0;
                wait_cnt++;
            end
        end
    end

    typedef struct {
        logic [32:0] ctrl;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          delay;
        logic [15:0] exp_rdata;
        int          lat;
        int          stalls;
        int          nbus;
        logic        we;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic [15:0] a1;
        logic [7:0]  d1;
    } vec_t;

    task automatic clear_bus_log();
        tr_addr.delete();
        tr_wdata.delete();
        tr_we.delete();
        stab_err = 0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat, stall_cycles, nvalid;
        bit released;
        logic [15:0] got_pc, got_rdata;
        logic [32:0] got_ctrl;
        lat = -1; stall_cycles = 0; nvalid = 0; released = 0;
        got_pc = '0; got_rdata = '0; got_ctrl = '0;
        ack_delay = v.delay;
        clear_bus_log();
        @(posedge clk); #1;
        en = 1'b1;
        control_signals_in = v.ctrl;
        pc_in = v.pc;
        addr_in = v.addr;
        wdata_in = v.wdata;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            if (valid_out) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c;
                    got_pc = pc_out;
                    got_rdata = rdata_out;
                    got_ctrl = control_signals_out;
                end
            end
            if (lat >= 0 && c >= lat + 1) break;
            if (!released && !stall) begin
                @(posedge clk); #1;
                en = 1'b0;
                released = 1;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
        chk({tag, "_valid_count"}, 64'(nvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
        chk({tag, "_pc"}, 64'(got_pc), 64'(v.pc));
        chk({tag, "_ctrl"}, 64'(got_ctrl), 64'(v.ctrl));
        chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(v.stalls));
        chk({tag, "_bus_count"}, 64'(tr_addr.size()), 64'(v.nbus));
        chk({tag, "_bus_stable"}, 64'(stab_err), 64'd0);
        if (v.nbus >= 1 && tr_addr.size() >= 1) begin
            chk({tag, "_b0_addr"}, 64'(tr_addr[0]), 64'(v.a0));
            chk({tag, "_b0_wdata"}, 64'(tr_wdata[0]), 64'(v.d0));
            chk({tag, "_b0_we"}, 64'(tr_we[0]), 64'(v.we));
        end
        if (v.nbus >= 2 && tr_addr.size() >= 2) begin
            chk({tag, "_b1_addr"}, 64'(tr_addr[1]), 64'(v.a1));
            chk({tag, "_b1_wdata"}, 64'(tr_wdata[1]), 64'(v.d1));
            chk({tag, "_b1_we"}, 64'(tr_we[1]), 64'(v.we));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_bus"}, {39'd0, bus_req, bus_we, bus_addr, bus_wdata}, 64'd0);
        chk({tag, "_ctrl_out"}, 64'(control_signals_out), 64'd0);
        chk({tag, "_pc_rdata"}, {32'd0, pc_out, rdata_out}, 64'd0);
        chk({tag, "_valid"}, 64'(valid_out), 64'd0);
    endtask

    vec_t vecs[7];
    vec_t alu_after_rst;

    initial begin
        vecs[0] = '{33'h1_0000_ABC0, 16'h0040, 16'h1234, 16'h0000, 0, 16'h1234, 1, 0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vecs[1] = '{33'h0_0000_0011, 16'h0042, 16'h2000, 16'h0000, 0, 16'h00A5, 3, 2, 1, 1'b0, 16'h2000, 8'h00, 16'h0000, 8'h00};
        vecs[2] = '{33'h0_8000_0008, 16'h0044, 16'hFFFF, 16'hBEEF, 2, 16'h0000, 8, 7, 2, 1'b1, 16'hFFFF, 8'hEF, 16'h0000, 8'hBE};
        vecs[3] = '{33'h0_0000_0006, 16'h0046, 16'h4000, 16'h1234, 0, 16'h0000, 3, 2, 1, 1'b1, 16'h4000, 8'h34, 16'h0000, 8'h00};
        vecs[4] = '{33'h0_0000_0002, 16'h0048, 16'h3010, 16'h5566, 1, 16'hB4B5, 6, 5, 2, 1'b0, 16'h3010, 8'h66, 16'h3011, 8'h55};
        vecs[5] = '{33'h0_0000_0004, 16'h004A, 16'h00FF, 16'h77C3, 0, 16'h0000, 3, 2, 1, 1'b1, 16'h00FF, 8'hC3, 16'h0000, 8'h00};
        vecs[6] = '{33'h1_FFFF_FFF3, 16'h004C, 16'h10FE, 16'h0000, 0, 16'h5A5B, 4, 3, 2, 1'b0, 16'h10FE, 8'h00, 16'h10FF, 8'h00};
        alu_after_rst = '{33'h0_1234_5670, 16'h0200, 16'hCAFE, 16'h0000, 0, 16'hCAFE, 1, 0, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};

        // Reset with a memory op presented: everything must read 0.
        rst = 1'b1;
        en = 1'b1;
        control_signals_in = 33'h0_0000_0008;
        pc_in = 16'h1111;
        addr_in = 16'h2222;
        wdata_in = 16'h3333;
        bus_ack = 1'b0;
        bus_rdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        #1 en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset in the middle of a word read, while BYTE1 waits for ack.
        begin
            int nreq, nval;
            bit got_first;
            ack_delay = 3;
            clear_bus_log();
            got_first = 0;
            @(posedge clk); #1;
            en = 1'b1;
            control_signals_in = 33'h0_0000_0002;
            pc_in = 16'h0300;
            addr_in = 16'h3010;
            wdata_in = 16'h0000;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (tr_addr.size() >= 1) begin
                    got_first = 1;
                    break;
                end
            end
            chk("midrst_first_byte_seen", 64'(got_first), 64'd1);
            @(negedge clk);
            chk("midrst_in_byte1_req", {47'd0, bus_req, bus_addr}, {47'd0, 1'b1, 16'h3011});
            #1 rst = 1'b1;
            en = 1'b0;
            #1;
            chk_all_zero("midrst");
            @(posedge clk); #1 rst = 1'b0;
            nreq = 0; nval = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus_req) nreq++;
                if (valid_out) nval++;
            end
            chk("midrst_no_bus_req_after", 64'(nreq), 64'd0);
            chk("midrst_no_valid_after", 64'(nval), 64'd0);
            chk("midrst_bus_count", 64'(tr_addr.size()), 64'd1);
            run_vec("alu_after_rst", alu_after_rst);
        end

        // Word read followed by an ALU op that appears while stall is high.
        begin
            int nval;
            logic [15:0] vpc[$];
            logic [15:0] vrd[$];
            int vcyc[$];
            logic [3:0] stall_seen;
            ack_delay = 0;
            clear_bus_log();
            nval = 0;
            stall_seen = '0;
            @(posedge clk); #1;
            en = 1'b1;
            control_signals_in = 33'h0_0000_0002;
            pc_in = 16'h0100;
            addr_in = 16'h10FE;
            wdata_in = 16'h0000;
            @(negedge clk);
            stall_seen[0] = stall;
            @(posedge clk); #1;
            control_signals_in = 33'h1_5555_0000;
            pc_in = 16'h0102;
            addr_in = 16'h9ABC;
            for (int c = 1; c < 8; c++) begin
                @(negedge clk);
                if (c < 4) stall_seen[c] = stall;
                if (valid_out) begin
                    nval++;
                    vcyc.push_back(c);
                    vpc.push_back(pc_out);
                    vrd.push_back(rdata_out);
                end
                if (c == 4) begin
                    @(posedge clk); #1;
                    en = 1'b0;
                end
            end
            chk("b2b_stall_pattern", 64'(stall_seen), 64'h7);
            chk("b2b_valid_count", 64'(nval), 64'd2);
            chk("b2b_bus_count", 64'(tr_addr.size()), 64'd2);
            if (nval >= 2) begin
                chk("b2b_first_cycle", 64'(vcyc[0]), 64'd4);
                chk("b2b_first_pc", 64'(vpc[0]), 64'h0100);
                chk("b2b_first_rdata", 64'(vrd[0]), 64'h5A5B);
                chk("b2b_second_cycle", 64'(vcyc[1]), 64'd5);
                chk("b2b_second_pc", 64'(vpc[1]), 64'h0102);
                chk("b2b_second_rdata", 64'(vrd[1]), 64'h9ABC);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have en, input, 1: an instruction is present on the inputs this cycle.
REQ-004 SHALL have pc_in, input, 16: PC of the incoming instruction.
REQ-005 SHALL have control_signals_in, input, 33: control word, decoded via ctrl_decode (memReadB, memReadW, memWriteB, memWriteW).
REQ-006 SHALL have addr_in, input, 16: ALU result; the memory address for memory ops, the pass-through value otherwise.
REQ-007 SHALL have wdata_in, input, 16: store data.
REQ-008 SHALL have stall, output, 1: upstream holds all inputs while this is high.
REQ-009 SHALL have bus_req, output, 1; bus_we, output, 1; bus_addr, output, 16; bus_wdata, output, 8: byte-wide memory request.
REQ-010 SHALL have bus_rdata, input, 8 and bus_ack, input, 1: memory read data and transfer-complete strobe.
REQ-011 SHALL have control_signals_out, output, 33; pc_out, output, 16; rdata_out, output, 16; valid_out, output, 1: registered results to the writeback stage.

Function
REQ-012 The op SHALL be classified as: write if memWriteB or memWriteW is set, else read if memReadB or memReadW is set, else none. Write takes priority over read. Word (W) takes priority over byte (B).
REQ-013 The block SHALL have the states IDLE, BYTE0, BYTE1 and DONE.
REQ-014 In IDLE with en=1 and op=none, at the next edge: control_signals_out<=control_signals_in, pc_out<=pc_in, rdata_out<=addr_in, valid_out<=1. The state stays IDLE. Latency is 1 cycle.
REQ-015 In IDLE with en=1 and op=read or op=write, the block SHALL:
- assert stall combinationally in that cycle;
- at the edge, capture pc, control, addr, wdata and op kind, and go to BYTE0.
REQ-016 stall SHALL equal (IDLE & en & op!=none) | BYTE0 | BYTE1. stall SHALL be 0 in DONE.
REQ-017 In BYTE0 the block SHALL drive bus_req=1, bus_addr=captured addr, bus_we=(op==write), bus_wdata=wdata[7:0].
REQ-018 On bus_ack in BYTE0: a read SHALL capture bus_rdata into data[7:0]. The next state is BYTE1 for a word op, DONE for a byte op.
REQ-019 In BYTE1 the block SHALL drive bus_req=1, bus_addr=addr+1 (16-bit wrap, 0xFFFF->0x0000), bus_wdata=wdata[15:8]. On bus_ack a read SHALL capture bus_rdata into data[15:8], and the next state is DONE.
REQ-020 Without bus_ack, BYTE0/BYTE1 SHALL hold, with bus_req and all bus outputs stable.
REQ-021 bus_req SHALL be 0 in IDLE and DONE. bus_ack SHALL be ignored when bus_req=0.
REQ-022 In DONE the block SHALL ignore en and the inputs. At the edge it SHALL register the captured pc and control, set valid_out<=1 and go to IDLE. rdata_out SHALL be:
- {8'h00, data[7:0]} for a byte read;
- data for a word read;
- 16'h0000 for a write.
REQ-023 valid_out SHALL be 1 for exactly one cycle per retired instruction, and 0 otherwise.
REQ-024 When valid_out is 0, control_signals_out, pc_out and rdata_out SHALL hold their previous values.
REQ-025 Latency with zero-wait ack SHALL be 3 cycles for a byte access and 4 cycles for a word access, from the input cycle to valid_out.

Reset
REQ-026 While rst=1, the block SHALL go immediately to IDLE and drive all outputs to 0: stall, bus_req, bus_we, bus_addr, bus_wdata, control_signals_out, pc_out, rdata_out, valid_out.
REQ-027 Reset during BYTE0/BYTE1 SHALL abort the transfer. After rst falls, no bus_req is issued for the aborted op and no valid_out is produced for it.

Verification
REQ-028 ALU op: en=1, op=none, addr_in=0x1234, pc_in=0x0040 -> next cycle valid_out=1, rdata_out=0x1234, pc_out=0x0040, stall never high.
REQ-029 Byte read: addr_in=0x2000, ack in the first req cycle with bus_rdata=0xA5 -> one bus cycle at 0x2000, bus_we=0, rdata_out=0x00A5, valid_out 3 cycles after input.
REQ-030 Word write with wait states: addr_in=0xFFFF, wdata_in=0xBEEF, ack delayed 2 cycles per byte:
- stall stays high throughout;
- bus writes 0xEF@0xFFFF, then 0xBE@0x0000;
- rdata_out=0x0000;
- bus outputs stable while waiting.
REQ-031 Priority: control has memReadW and memWriteB both set -> a single byte write occurs and no read occurs.
REQ-032 Reset mid-word-read (rst pulsed during BYTE1 wait) -> outputs 0 immediately, no valid_out; a subsequent ALU op completes normally in 1 cycle.
REQ-033 Back-to-back: a word read, then an ALU op presented while stall=1 -> the ALU op is accepted only after DONE. There is exactly one valid_out per instruction, in order.
